// File: rtl/slow_multiplier.sv
// Sequential shift-add unsigned multiplier: one multiplier bit per clock, full product plus a scaled result.
// Defining SLOW_MULTIPLIER_ROUND_EN makes scaled_o round half-up with saturation instead of truncating.
module slow_multiplier #(
  parameter int NBITS = 16,
  parameter int MBITS = 17,
  parameter int SHIFT = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          calc_i,
  input  logic [NBITS-1:0]              a_i,
  input  logic [MBITS-1:0]              b_i,
  output logic                          busy_o,
  output logic [NBITS+MBITS-1:0]        out_o,
  output logic [NBITS+MBITS-SHIFT-1:0]  scaled_o,
  output logic                          valid_o
);

  localparam int PW = NBITS + MBITS;
  localparam int AW = PW + 1;
  localparam int SW = PW - SHIFT;
  localparam int CW = $clog2(MBITS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_reg;
  state_t          state_next;
  logic [NBITS-1:0] a_reg;
  logic [MBITS-1:0] b_reg;
  logic [AW-1:0]   acc_reg;
  logic [CW-1:0]   cnt_reg;
  logic [PW-1:0]   out_reg;
  logic [SW-1:0]   scaled_reg;

  logic [NBITS:0]  hi_sum;
  logic [AW-1:0]   acc_step;
  logic [PW-1:0]   product;
  logic [SW-1:0]   scaled_calc;
  logic            last_iter;
  logic            start;

  // The partial sum never exceeds a*2^MBITS, so the NBITS+1 upper bits absorb the carry.
  assign hi_sum    = acc_reg[AW-1:MBITS] + (b_reg[0] ? {1'b0, a_reg} : {(NBITS+1){1'b0}});
  assign acc_step  = {hi_sum, acc_reg[MBITS-1:0]} >> 1;
  assign product   = acc_step[PW-1:0];
  assign last_iter = (state_reg == RUN) && (cnt_reg == CW'(1));
  assign start     = calc_i && (state_reg != RUN);

`ifdef SLOW_MULTIPLIER_ROUND_EN
  logic [SW:0] rounded;

  // Adding half an LSB before the shift equals adding the first dropped bit after it.
  assign rounded     = {1'b0, product[PW-1:SHIFT]} + {{SW{1'b0}}, product[SHIFT-1]};
  assign scaled_calc = rounded[SW] ? {SW{1'b1}} : rounded[SW-1:0];
`else
  assign scaled_calc = product[PW-1:SHIFT];
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg  <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      out_reg    <= '0;
      scaled_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (start) begin
        a_reg   <= a_i;
        b_reg   <= b_i;
        acc_reg <= '0;
        cnt_reg <= CW'(MBITS);
      end else if (state_reg == RUN) begin
        acc_reg <= acc_step;
        b_reg   <= b_reg >> 1;
        cnt_reg <= cnt_reg - CW'(1);
      end
      // Results are captured on the final iteration so they are present throughout the DONE cycle.
      if (last_iter) begin
        out_reg    <= product;
        scaled_reg <= scaled_calc;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (calc_i) state_next = RUN;
      RUN:     if (cnt_reg == CW'(1)) state_next = DONE;
      DONE:    state_next = calc_i ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy_o   = (state_reg == RUN);
  assign valid_o  = (state_reg == DONE);
  assign out_o    = out_reg;
  assign scaled_o = scaled_reg;

endmodule

// File: tb/tb_slow_multiplier.sv
// Directed self-checking bench for slow_multiplier at default parameters.
// Expected scaled values follow SLOW_MULTIPLIER_ROUND_EN when the bench is built with it.
module tb_slow_multiplier;

  logic        clk;
  logic        rst_i;
  logic        calc_i;
  logic [15:0] a_i;
  logic [16:0] b_i;
  logic        busy_o;
  logic [32:0] out_o;
  logic [16:0] scaled_o;
  logic        valid_o;

  int errors = 0;
  int checks = 0;
  logic [32:0] last_out;
  logic [16:0] last_scaled;

  slow_multiplier dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .calc_i  (calc_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .busy_o  (busy_o),
    .out_o   (out_o),
    .scaled_o(scaled_o),
    .valid_o (valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge; edge 0 is the next posedge, operands are scrambled right after it.
  task automatic start_op(input logic [15:0] a, input logic [16:0] b);
    calc_i = 1'b1;
    a_i    = a;
    b_i    = b;
    @(posedge clk);
    #1;
    calc_i = 1'b0;
    a_i    = 16'hBEEF;
    b_i    = 17'h15A5A;
  endtask

  task automatic test_reset();
    rst_i  = 1'b1;
    calc_i = 1'b1;
    a_i    = 16'd9;
    b_i    = 17'd9;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_o); end
    checks++; if (out_o !== 33'd0) begin errors++; $display("FAIL reset_out: got %0h want 0", out_o); end
    checks++; if (scaled_o !== 17'd0) begin errors++; $display("FAIL reset_scaled: got %0h want 0", scaled_o); end
    calc_i = 1'b0;
    rst_i  = 1'b0;
    @(negedge clk);
    last_out    = 33'd0;
    last_scaled = 17'd0;
    $display("reset: outputs cleared");
  endtask

  task automatic test_recip();
    start_op(16'd1000, 17'd8192);
    for (int c = 0; c <= 17; c++) begin
      @(negedge clk);
      checks++;
      if (busy_o !== (c < 17)) begin errors++; $display("FAIL recip_busy c%0d: got %b want %b", c, busy_o, (c < 17)); end
      checks++;
      if (valid_o !== (c == 17)) begin errors++; $display("FAIL recip_valid c%0d: got %b want %b", c, valid_o, (c == 17)); end
      if (c < 17) begin
        checks++;
        if (out_o !== last_out) begin errors++; $display("FAIL recip_hold c%0d: got %0h want %0h", c, out_o, last_out); end
      end
    end
    checks++; if (out_o !== 33'd8192000) begin errors++; $display("FAIL recip_out: got %0d want 8192000", out_o); end
    checks++; if (scaled_o !== 17'd125) begin errors++; $display("FAIL recip_scaled: got %0d want 125", scaled_o); end
    last_out = 33'd8192000; last_scaled = 17'd125;
    @(negedge clk);
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL recip_valid_drop: got %b want 0", valid_o); end
    $display("recip: 1000*8192 out=%0d scaled=%0d", out_o, scaled_o);
  endtask

  task automatic test_max();
    int cyc;
    start_op(16'hFFFF, 17'h1FFFF);
    @(negedge clk);
    cyc = 0;
    while (valid_o !== 1'b1 && cyc < 40) begin
      checks++; if (out_o !== last_out) begin errors++; $display("FAIL max_hold c%0d: got %0h want %0h", cyc, out_o, last_out); end
      @(negedge clk); cyc++;
    end
    checks++; if (cyc != 17) begin errors++; $display("FAIL max_latency: got %0d want 17", cyc); end
    checks++; if (out_o !== 33'h1FFFD0001) begin errors++; $display("FAIL max_out: got %0h want 1fffd0001", out_o); end
    checks++; if (scaled_o !== 17'h1FFFD) begin errors++; $display("FAIL max_scaled: got %0h want 1fffd", scaled_o); end
    last_out = 33'h1FFFD0001; last_scaled = 17'h1FFFD;
    @(negedge clk);
    $display("max: out=%0h scaled=%0h latency=%0d", last_out, last_scaled, cyc);
  endtask

  task automatic test_round();
    int cyc;
    logic [16:0] exp_a;
    logic [16:0] exp_b;
`ifdef SLOW_MULTIPLIER_ROUND_EN
    exp_a = 17'd2;
    exp_b = 17'd42725;
`else
    exp_a = 17'd1;
    exp_b = 17'd42724;
`endif
    start_op(16'd3, 17'h08000);
    @(negedge clk);
    cyc = 0;
    while (valid_o !== 1'b1 && cyc < 40) begin @(negedge clk); cyc++; end
    checks++; if (cyc != 17) begin errors++; $display("FAIL round_latency: got %0d want 17", cyc); end
    checks++; if (out_o !== 33'h18000) begin errors++; $display("FAIL round_out: got %0h want 18000", out_o); end
    checks++; if (scaled_o !== exp_a) begin errors++; $display("FAIL round_scaled: got %0d want %0d", scaled_o, exp_a); end
    @(negedge clk);
    start_op(16'd40000, 17'd70000);
    @(negedge clk);
    cyc = 0;
    while (valid_o !== 1'b1 && cyc < 40) begin @(negedge clk); cyc++; end
    checks++; if (out_o !== 33'd2800000000) begin errors++; $display("FAIL round2_out: got %0d want 2800000000", out_o); end
    checks++; if (scaled_o !== exp_b) begin errors++; $display("FAIL round2_scaled: got %0d want %0d", scaled_o, exp_b); end
    last_out = 33'd2800000000; last_scaled = exp_b;
    @(negedge clk);
    $display("round: 3*0x8000 scaled=%0d, 40000*70000 scaled=%0d", exp_a, exp_b);
  endtask

  task automatic test_zero_busy_ignore();
    int pulses;
    int first;
    start_op(16'd0, 17'h1FFFF);
    pulses = 0;
    first  = -1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (valid_o === 1'b1) begin
        pulses++;
        if (first < 0) first = c;
      end
      if (c < 17) begin
        checks++;
        if (out_o !== last_out) begin errors++; $display("FAIL zero_hold c%0d: got %0h want %0h", c, out_o, last_out); end
      end
      if (c == 17) begin
        checks++; if (out_o !== 33'd0) begin errors++; $display("FAIL zero_out: got %0h want 0", out_o); end
        checks++; if (scaled_o !== 17'd0) begin errors++; $display("FAIL zero_scaled: got %0h want 0", scaled_o); end
      end
      if (c == 5) begin calc_i = 1'b1; a_i = 16'd7; b_i = 17'd9; end
      if (c == 6) calc_i = 1'b0;
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL zero_pulses: got %0d want 1", pulses); end
    checks++; if (first != 17) begin errors++; $display("FAIL zero_valid_cycle: got %0d want 17", first); end
    checks++; if (out_o !== 33'd0) begin errors++; $display("FAIL zero_ignored_out: got %0h want 0", out_o); end
    last_out = 33'd0; last_scaled = 17'd0;
    $display("zero_busy_ignore: pulses=%0d first_valid=%0d", pulses, first);
  endtask

  task automatic test_back_to_back();
    int cyc;
    start_op(16'd12, 17'd34);
    @(negedge clk);
    cyc = 0;
    while (valid_o !== 1'b1 && cyc < 40) begin @(negedge clk); cyc++; end
    checks++; if (out_o !== 33'd408) begin errors++; $display("FAIL b2b_first_out: got %0d want 408", out_o); end
    start_op(16'd5, 17'd6);
    for (int c = 0; c <= 17; c++) begin
      @(negedge clk);
      if (c < 17) begin
        checks++;
        if (out_o !== 33'd408 || busy_o !== 1'b1 || valid_o !== 1'b0)
          begin errors++; $display("FAIL b2b_hold c%0d: out=%0d busy=%b valid=%b want 408 1 0", c, out_o, busy_o, valid_o); end
      end
    end
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b want 1", valid_o); end
    checks++; if (out_o !== 33'd30) begin errors++; $display("FAIL b2b_out: got %0d want 30", out_o); end
    checks++; if (scaled_o !== 17'd0) begin errors++; $display("FAIL b2b_scaled: got %0d want 0", scaled_o); end
    last_out = 33'd30; last_scaled = 17'd0;
    @(negedge clk);
    $display("back_to_back: 12*34=408 then 5*6=%0d", out_o);
  endtask

  task automatic test_reset_midop();
    int pulses;
    int cyc;
    start_op(16'd100, 17'd100);
    for (int c = 0; c <= 8; c++) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy_o); end
    checks++; if (out_o !== 33'd0) begin errors++; $display("FAIL midrst_out: got %0h want 0", out_o); end
    checks++; if (scaled_o !== 17'd0) begin errors++; $display("FAIL midrst_scaled: got %0h want 0", scaled_o); end
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (valid_o === 1'b1) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL midrst_no_valid: got %0d want 0", pulses); end
    start_op(16'd100, 17'd100);
    @(negedge clk);
    cyc = 0;
    while (valid_o !== 1'b1 && cyc < 40) begin @(negedge clk); cyc++; end
    checks++; if (cyc != 17) begin errors++; $display("FAIL midrst_latency: got %0d want 17", cyc); end
    checks++; if (out_o !== 33'd10000) begin errors++; $display("FAIL midrst_out2: got %0d want 10000", out_o); end
    @(negedge clk);
    $display("reset_midop: aborted, restart out=10000 latency=%0d", cyc);
  endtask

  initial begin
    rst_i  = 1'b1;
    calc_i = 1'b0;
    a_i    = '0;
    b_i    = '0;
    last_out    = '0;
    last_scaled = '0;
    test_reset();
    test_recip();
    test_max();
    test_round();
    test_zero_busy_ignore();
    test_back_to_back();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
